// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants and the IF/ID control encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [XLEN-1:0] HALT_INSTR = 32'h0000_0063;

  // What the IF/ID register does at the next clock edge.
  typedef enum logic [1:0] {
    IFID_LOAD  = 2'd0,
    IFID_HOLD  = 2'd1,
    IFID_FLUSH = 2'd2
  } ifid_ctrl_e;

  // Clears the two low address bits: no compressed instructions, so every
  // fetch address is word aligned.
  function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] addr);
    return addr & ~{{(XLEN-2){1'b0}}, 2'b11};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and flush-to-bubble control.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  ifid_ctrl_e      ctrl_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;

  // Next-state selection: capture the fetched word, keep the current one,
  // or replace it with a bubble.
  always_comb begin
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    case (ctrl_i)
      IFID_LOAD: begin
        pc_d       = pc_i;
        pc_plus4_d = pc_plus4_i;
        instr_d    = instr_i;
        valid_d    = 1'b1;
      end
      IFID_FLUSH: begin
        pc_d       = '0;
        pc_plus4_d = '0;
        instr_d    = NOP_INSTR;
        valid_d    = 1'b0;
      end
      default: begin
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
      end
    endcase
  end

  // Register update; reset leaves a bubble in the stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID capture
// and the sticky self-loop halt flag.
module if_fetch_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic [XLEN-1:0] ifid_instr,
  output logic            ifid_valid,
  output logic            halt
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcPlus4;
  logic            halt_q, halt_d;
  ifid_ctrl_e      ifidCtrl;

  // Wraps naturally modulo 2^32.
  assign pcPlus4 = pc_q + XLEN'(4);

  // Next-PC and IF/ID control: a redirect squashes the wrong-path fetch
  // even while stalled, a stall freezes everything, otherwise advance.
  always_comb begin
    pc_d     = pcPlus4;
    ifidCtrl = IFID_LOAD;
    if (redirect_valid) begin
      pc_d     = alignPc(redirect_target);
      ifidCtrl = IFID_FLUSH;
    end else if (stall) begin
      pc_d     = pc_q;
      ifidCtrl = IFID_HOLD;
    end
  end

  // Halt is only raised by a HALT word that actually lands in IF/ID as a
  // valid instruction; squashed or stalled words never set it.
  always_comb begin
    halt_d = halt_q;
    if (ifidCtrl == IFID_LOAD && imem_instr == HALT_INSTR) begin
      halt_d = 1'b1;
    end
  end

  // PC and halt state; reset overrides stall and redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      halt_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      halt_q <= halt_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .ctrl_i     (ifidCtrl),
    .pc_i       (pc_q),
    .pc_plus4_i (pcPlus4),
    .instr_i    (imem_instr),
    .pc_o       (ifid_pc),
    .pc_plus4_o (ifid_pc_plus4),
    .instr_o    (ifid_instr),
    .valid_o    (ifid_valid)
  );

  assign imem_addr = pc_q;
  assign halt      = halt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for the instruction-fetch stage.
module tb_if_fetch_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        halt;

  logic [31:0] mem [0:63];

  int testsRun  = 0;
  int failCount = 0;

  if_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .ifid_pc         (ifid_pc),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_instr      (ifid_instr),
    .ifid_valid      (ifid_valid),
    .halt            (halt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Zero-latency instruction memory, word indexed by address bits [7:2].
  always_comb begin
    imem_instr = mem[imem_addr[7:2]];
  end

  // Drive inputs, then move to 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic stl,
                               input logic rv, input logic [31:0] rt);
    reset           = rst;
    stall           = stl;
    redirect_valid  = rv;
    redirect_target = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Linear sequence of directed steps with hand-computed expectations.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h00C0_0413;
    mem[1]  = 32'h0090_0493;
    mem[2]  = 32'h0000_0063;
    mem[63] = 32'h0010_0093;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_pc",     imem_addr,     32'h0);
    checkOutput("rst_ifpc",   ifid_pc,       32'h0);
    checkOutput("rst_ifpc4",  ifid_pc_plus4, 32'h0);
    checkOutput("rst_instr",  ifid_instr,    32'h0000_0013);
    checkOutput("rst_valid",  {31'b0, ifid_valid}, 32'h0);
    checkOutput("rst_halt",   {31'b0, halt},       32'h0);

    // Straight-line program ending in the self-loop
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("e1_ifpc",    ifid_pc,       32'h0);
    checkOutput("e1_instr",   ifid_instr,    32'h00C0_0413);
    checkOutput("e1_valid",   {31'b0, ifid_valid}, 32'h1);
    checkOutput("e1_pc",      imem_addr,     32'h4);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("e2_ifpc",    ifid_pc,       32'h4);
    checkOutput("e2_instr",   ifid_instr,    32'h0090_0493);
    checkOutput("e2_halt",    {31'b0, halt}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("e3_ifpc",    ifid_pc,       32'h8);
    checkOutput("e3_ifpc4",   ifid_pc_plus4, 32'hC);
    checkOutput("e3_halt",    {31'b0, halt}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("e4_halt",    {31'b0, halt}, 32'h1);
    checkOutput("e4_pc",      imem_addr,     32'h10);

    // Stall at pc_q=4 for two edges
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("r2_halt",    {31'b0, halt}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("s0_pc",      imem_addr,     32'h4);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("st_pc",    imem_addr,     32'h4);
      checkOutput("st_ifpc",  ifid_pc,       32'h0);
      checkOutput("st_instr", ifid_instr,    32'h00C0_0413);
      checkOutput("st_valid", {31'b0, ifid_valid}, 32'h1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("sr_ifpc",    ifid_pc,       32'h4);
    checkOutput("sr_instr",   ifid_instr,    32'h0090_0493);
    checkOutput("sr_pc",      imem_addr,     32'h8);

    // Advance to pc_q=0x18, then redirect to 0x8
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("adv_pc",     imem_addr,     32'h18);
    checkOutput("adv_ifpc",   ifid_pc,       32'h14);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h8);
    checkOutput("rd_pc",      imem_addr,     32'h8);
    checkOutput("rd_valid",   {31'b0, ifid_valid}, 32'h0);
    checkOutput("rd_instr",   ifid_instr,    32'h0000_0013);
    checkOutput("rd_ifpc",    ifid_pc,       32'h0);
    checkOutput("rd_ifpc4",   ifid_pc_plus4, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rd2_ifpc",   ifid_pc,       32'h8);
    checkOutput("rd2_valid",  {31'b0, ifid_valid}, 32'h1);
    checkOutput("rd2_pc",     imem_addr,     32'hC);

    // Redirect beats stall; misaligned target is word aligned
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h20);
    checkOutput("rs_pc",      imem_addr,     32'h20);
    checkOutput("rs_valid",   {31'b0, ifid_valid}, 32'h0);
    checkOutput("rs_instr",   ifid_instr,    32'h0000_0013);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h22);
    checkOutput("mis_pc",     imem_addr,     32'h20);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("mis_ifpc",   ifid_pc,       32'h20);
    checkOutput("mis_valid",  {31'b0, ifid_valid}, 32'h1);
    checkOutput("mis_next",   imem_addr,     32'h24);

    // PC wrap at the top of the address space
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    checkOutput("wr_pc",      imem_addr,     32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wr_ifpc",    ifid_pc,       32'hFFFF_FFFC);
    checkOutput("wr_ifpc4",   ifid_pc_plus4, 32'h0);
    checkOutput("wr_instr",   ifid_instr,    32'h0010_0093);
    checkOutput("wr_next",    imem_addr,     32'h0);

    // Reset during a stall, while halt is set
    checkOutput("pre_halt",   {31'b0, halt}, 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rst_st_pc",  imem_addr,     32'h0);
    checkOutput("rst_st_vld", {31'b0, ifid_valid}, 32'h0);
    checkOutput("rst_st_hlt", {31'b0, halt}, 32'h0);
    checkOutput("rst_st_ins", ifid_instr,    32'h0000_0013);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_st_run", imem_addr,     32'h4);

    // Reset during a redirect
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
    checkOutput("rst_rd_pc",  imem_addr,     32'h0);
    checkOutput("rst_rd_vld", {31'b0, ifid_valid}, 32'h0);
    checkOutput("rst_rd_ifp", ifid_pc,       32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_rd_nxt", ifid_pc,       32'h0);
    checkOutput("rst_rd_ins", ifid_instr,    32'h00C0_0413);

    // HALT word fetched but squashed by a redirect never sets halt
    mem[5] = 32'h0000_0063;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h14);
    checkOutput("sq_pc",      imem_addr,     32'h14);
    checkOutput("sq_fetch",   imem_instr,    32'h0000_0063);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
    checkOutput("sq_halt",    {31'b0, halt}, 32'h0);
    checkOutput("sq_valid",   {31'b0, ifid_valid}, 32'h0);
    checkOutput("sq_pc2",     imem_addr,     32'h40);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("sq_ifpc",    ifid_pc,       32'h40);
    checkOutput("sq_halt2",   {31'b0, halt}, 32'h0);

    // Stalling on a HALT word keeps it out of IF/ID, so halt stays clear
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h14);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("sth_halt",   {31'b0, halt}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("sth_halt2",  {31'b0, halt}, 32'h1);
    checkOutput("sth_ifpc",   ifid_pc,       32'h14);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
